// File: rtl/nervous_shock_if.sv
// Sample/status bundle for the nervous shock monitor.
// The master drives samples in; the slave (the monitor) returns per-channel status.
interface nervous_shock_if #(
    parameter int unsigned CHANNELS = 4
) ();
    logic                  sample_valid;
    logic [CHANNELS-1:0]   inputdata;
    logic [2*CHANNELS-1:0] nervousAbnormality;
    logic                  shock_alarm;
    logic                  window_done;

    modport master (
        output sample_valid,
        output inputdata,
        input  nervousAbnormality,
        input  shock_alarm,
        input  window_done
    );

    modport slave (
        input  sample_valid,
        input  inputdata,
        output nervousAbnormality,
        output shock_alarm,
        output window_done
    );
endinterface

// File: rtl/nervous_shock_monitor.sv
// Per-channel toggle-rate classifier over fixed sample windows, with stuck-sensor
// detection; all status outputs come straight from flops.
module nervous_shock_monitor #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned WARN_TH   = 4,
    parameter int unsigned SHOCK_TH  = 8,
    parameter int unsigned STUCK_LEN = 32
) (
    input  logic           clock,
    input  logic           reset,
    nervous_shock_if.slave bus
);
    localparam int unsigned WW = $clog2(WINDOW);
    localparam int unsigned TW = $clog2(WINDOW + 1);
    localparam int unsigned SW = $clog2(STUCK_LEN + 1);

    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [TW-1:0] WARN_T    = TW'(WARN_TH);
    localparam logic [TW-1:0] SHOCK_T   = TW'(SHOCK_TH);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LEN);

    typedef enum logic {
        NO_HISTORY = 1'b0,
        RUN        = 1'b1
    } hist_e;

    hist_e                         hist_q, hist_d;
    logic [WW-1:0]                 win_q, win_d;
    logic [CHANNELS-1:0]           prev_q, prev_d;
    logic [CHANNELS-1:0]           stuck_q, stuck_d;
    logic [CHANNELS-1:0][TW-1:0]   tog_q, tog_d;
    logic [CHANNELS-1:0][1:0]      cls_q, cls_d;
    logic [CHANNELS-1:0][SW-1:0]   scnt_q, scnt_d;
    logic [2*CHANNELS-1:0]         abn_q, abn_d;
    logic                          alarm_q, alarm_d;
    logic                          done_q, done_d;

    logic                          close;
    logic [CHANNELS-1:0]           trans;
    logic [CHANNELS-1:0][TW-1:0]   tog_inc;

    // Next-state: every counter and flag advances only on an accepted sample
    always_comb begin
        hist_d  = hist_q;
        win_d   = win_q;
        prev_d  = prev_q;
        stuck_d = stuck_q;
        tog_d   = tog_q;
        cls_d   = cls_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        close   = 1'b0;
        trans   = '0;
        tog_inc = tog_q;
        abn_d   = '0;
        alarm_d = 1'b0;

        if (bus.sample_valid) begin
            hist_d = RUN;
            prev_d = bus.inputdata;
            close  = (win_q == WIN_LAST);
            win_d  = close ? '0 : win_q + WW'(1);
            done_d = close;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                trans[c]   = (hist_q == RUN) && (bus.inputdata[c] != prev_q[c]);
                tog_inc[c] = tog_q[c] + TW'(trans[c]);
                // The closing sample's own transition is part of the window being judged
                if (close) begin
                    tog_d[c] = '0;
                    if (tog_inc[c] >= SHOCK_T)     cls_d[c] = 2'b10;
                    else if (tog_inc[c] >= WARN_T) cls_d[c] = 2'b01;
                    else                           cls_d[c] = 2'b00;
                end else begin
                    tog_d[c] = tog_inc[c];
                end
                if (trans[c])                    scnt_d[c] = '0;
                else if (scnt_q[c] != STUCK_MAX) scnt_d[c] = scnt_q[c] + SW'(1);
                stuck_d[c] = !trans[c] && (stuck_q[c] || (scnt_d[c] == STUCK_MAX));
            end
        end

        // Status is registered from next-state so it updates on the accepting edge
        for (int c = 0; c < int'(CHANNELS); c++) begin
            abn_d[2*c +: 2] = stuck_d[c] ? 2'b11 : cls_d[c];
            alarm_d         = alarm_d | (abn_d[2*c +: 2] == 2'b10);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q  <= NO_HISTORY;
            win_q   <= '0;
            prev_q  <= '0;
            stuck_q <= '0;
            tog_q   <= '0;
            cls_q   <= '0;
            scnt_q  <= '0;
            abn_q   <= '0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            win_q   <= win_d;
            prev_q  <= prev_d;
            stuck_q <= stuck_d;
            tog_q   <= tog_d;
            cls_q   <= cls_d;
            scnt_q  <= scnt_d;
            abn_q   <= abn_d;
            alarm_q <= alarm_d;
            done_q  <= done_d;
        end
    end

    assign bus.nervousAbnormality = abn_q;
    assign bus.shock_alarm        = alarm_q;
    assign bus.window_done        = done_q;
endmodule

// File: tb/tb_nervous_shock_monitor.sv
// Bench for nervous_shock_monitor: directed scenarios plus random samples checked
// against a run-length / toggle-count reference model.
module tb_nervous_shock_monitor;
    localparam int CH      = 4;
    localparam int WIN     = 16;
    localparam int WARN    = 4;
    localparam int SHOCK   = 8;
    localparam int STUCK   = 32;
    localparam int STUCK_B = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    nervous_shock_if #(.CHANNELS(CH)) bus_a ();
    nervous_shock_if #(.CHANNELS(CH)) bus_b ();
    assign bus_b.sample_valid = bus_a.sample_valid;
    assign bus_b.inputdata    = bus_a.inputdata;

    nervous_shock_monitor #(
        .CHANNELS(CH), .WINDOW(WIN), .WARN_TH(WARN), .SHOCK_TH(SHOCK), .STUCK_LEN(STUCK)
    ) dut_a (.clock(clk), .reset(rst), .bus(bus_a));

    nervous_shock_monitor #(
        .CHANNELS(CH), .WINDOW(WIN), .WARN_TH(WARN), .SHOCK_TH(SHOCK), .STUCK_LEN(STUCK_B)
    ) dut_b (.clock(clk), .reset(rst), .bus(bus_b));

    // Reference model of dut_a: per-channel toggles this window, run length since last transition
    int          m_tog [CH];
    int          m_run [CH];
    int          m_cls [CH];
    logic [CH-1:0] m_prev;
    bit          m_hist;
    int          m_n;
    bit          m_done;
    logic [CH-1:0] last_d;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_tog[c] = 0; m_run[c] = 0; m_cls[c] = 0;
        end
        m_prev = '0; m_hist = 1'b0; m_n = 0; m_done = 1'b0;
    endtask

    task automatic model_accept(input logic [CH-1:0] d);
        for (int c = 0; c < CH; c++) begin
            if (m_hist && d[c] != m_prev[c]) begin
                m_tog[c]++;
                m_run[c] = 0;
            end else begin
                m_run[c]++;
            end
        end
        m_prev = d; m_hist = 1'b1; m_n++;
        if (m_n == WIN) begin
            m_n = 0; m_done = 1'b1;
            for (int c = 0; c < CH; c++) begin
                m_cls[c] = (m_tog[c] >= SHOCK) ? 2 : (m_tog[c] >= WARN) ? 1 : 0;
                m_tog[c] = 0;
            end
        end
    endtask

    function automatic logic [2*CH-1:0] exp_abn();
        logic [2*CH-1:0] e;
        for (int c = 0; c < CH; c++)
            e[2*c +: 2] = (m_run[c] >= STUCK) ? 2'b11 : 2'(m_cls[c]);
        return e;
    endfunction

    function automatic logic exp_alarm();
        logic [2*CH-1:0] e;
        logic a;
        e = exp_abn();
        a = 1'b0;
        for (int c = 0; c < CH; c++) a = a | (e[2*c +: 2] == 2'b10);
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [CH-1:0] d);
        @(negedge clk);
        bus_a.sample_valid = v;
        bus_a.inputdata    = d;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (v) begin
            model_accept(d);
            last_d = d;
        end
        check("abn",   32'(bus_a.nervousAbnormality), 32'(exp_abn()));
        check("alarm", 32'(bus_a.shock_alarm),        32'(exp_alarm()));
        check("done",  32'(bus_a.window_done),        32'(m_done));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_a.sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_abn",   32'(bus_a.nervousAbnormality), 32'd0);
        check("rst_alarm", 32'(bus_a.shock_alarm),        32'd0);
        check("rst_done",  32'(bus_a.window_done),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [CH-1:0] d;
        int            ks [3];
        logic [1:0]    ex [3];
        int            dones;
        int            ns;

        bus_a.sample_valid = 1'b0;
        bus_a.inputdata    = '0;
        last_d             = '0;
        model_reset();
        do_reset();

        // Channel 0 alternating for one window: 15 toggles -> shock
        for (int i = 0; i < WIN; i++) begin
            d = '0;
            d[0] = (i % 2 == 0);
            step(1'b1, d);
        end
        check("alt_ch0",   32'(bus_a.nervousAbnormality[1:0]), 32'd2);
        check("alt_alarm", 32'(bus_a.shock_alarm), 32'd1);
        check("alt_done",  32'(bus_a.window_done), 32'd1);
        step(1'b0, last_d);
        check("alt_done_drop", 32'(bus_a.window_done), 32'd0);

        // Channel 1 with 4, 3, 8 toggles; channel 2 goes stuck at sample 32
        ks = '{4, 3, 8};
        ex = '{2'b01, 2'b00, 2'b10};
        ns = WIN;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WIN; i++) begin
                d = last_d;
                d[1] = d[1] ^ (i < ks[w]);
                if (ns == 32) d[2] = 1'b1;
                step(1'b1, d);
                ns++;
                if (ns == 31) check("ch2_pre_stuck", 32'(bus_a.nervousAbnormality[5:4]), 32'd0);
                if (ns == 32) check("ch2_stuck",     32'(bus_a.nervousAbnormality[5:4]), 32'd3);
                if (ns == 33) check("ch2_unstuck",   32'(bus_a.nervousAbnormality[5:4]), 32'd0);
            end
            check($sformatf("ch1_k%0d", ks[w]), 32'(bus_a.nervousAbnormality[3:2]), 32'(ex[w]));
        end

        // Alternating pattern with idle gaps: one window_done, shock class
        dones = 0;
        for (int i = 0; i < WIN; i++) begin
            d = last_d;
            d[0] = (i % 2 == 0);
            step(1'b1, d);
            dones += int'(bus_a.window_done);
            if (i < WIN - 1) begin
                for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
                    step(1'b0, CH'($urandom));
                    dones += int'(bus_a.window_done);
                end
            end
        end
        check("gap_done_last", 32'(bus_a.window_done), 32'd1);
        check("gap_done_cnt",  32'(dones), 32'd1);
        check("gap_ch0",       32'(bus_a.nervousAbnormality[1:0]), 32'd2);

        // Asynchronous reset mid-stream clears outputs before the next edge
        step(1'b0, last_d);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_abn",   32'(bus_a.nervousAbnormality), 32'd0);
        check("async_alarm", 32'(bus_a.shock_alarm),        32'd0);
        check("async_done",  32'(bus_a.window_done),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // First sample after reset differs from pre-reset bit yet must not count
        for (int i = 0; i < WIN; i++) begin
            d = last_d;
            if (i == 0) d[1] = ~last_d[1];
            else        d[1] = d[1] ^ (i <= 7);
            step(1'b1, d);
        end
        check("post_rst_ch1", 32'(bus_a.nervousAbnormality[3:2]), 32'd1);

        // Short-stuck instance: window close with 8 toggles and stuck on the same edge
        do_reset();
        for (int i = 0; i <= WIN; i++) begin
            d = '0;
            if (i >= 1 && i <= 8) d[3] = (i % 2 == 1);
            if (i == WIN)         d[3] = 1'b1;
            step(1'b1, d);
            if (i == WIN - 2) check("b_ch3_pre",   32'(bus_b.nervousAbnormality[7:6]), 32'd0);
            if (i == WIN - 1) begin
                check("b_ch3_stuck", 32'(bus_b.nervousAbnormality[7:6]), 32'd3);
                check("b_done",      32'(bus_b.window_done), 32'd1);
                check("b_alarm_off", 32'(bus_b.shock_alarm), 32'd0);
            end
            if (i == WIN) begin
                check("b_ch3_cls",  32'(bus_b.nervousAbnormality[7:6]), 32'd2);
                check("b_alarm_on", 32'(bus_b.shock_alarm), 32'd1);
            end
        end

        // Random traffic with per-channel toggle rates from busy to nearly stuck
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            d = last_d;
            d[0] = d[0] ^ ($urandom_range(0, 1) == 1);
            d[1] = d[1] ^ ($urandom_range(0, 2) == 0);
            d[2] = d[2] ^ ($urandom_range(0, 5) == 0);
            d[3] = d[3] ^ ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 3) != 0, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
